// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: receiver FSM encodings and oversample constants shared by the serial blocks
package serial_rx_pkg;
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;
  localparam logic [3:0] MID_SAMPLE = 4'd7;
  localparam logic [3:0] OS_LAST    = 4'd15;
endpackage

// File: rtl/serial_baud_tick.sv
// serial_baud_tick: divides clk by TICK_DIV into a one-clk oversample tick
module serial_baud_tick #(
  parameter int TICK_DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = en_i && cnt_q == LAST;
    cnt_d  = (clr_i || !en_i || tick_o) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/serial_rx.sv
// serial_rx: 16x oversampled 8N1 receiver with ready flag, framing error and sticky overrun
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int TICK_DIV = 651
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       clr_flag,
  output logic [0:7] rx_data,
  output logic       rx_flag,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);
  rx_state_e  state_q, state_d;
  logic [1:0] sync_q;
  logic [3:0] os_q, os_d;
  logic [2:0] bi_q, bi_d;
  logic [7:0] sr_q, sr_d, data_q;
  logic       flag_q, ferr_q, ovr_q;
  logic       rxs, tick, mid, last, load;
  serial_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (busy),
    .clr_i  (1'b0),
    .tick_o (tick)
  );
  assign rxs         = sync_q[1];
  assign busy        = state_q != RX_IDLE;
  assign rx_data     = data_q;
  assign rx_flag     = flag_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  always_comb begin
    mid     = tick && os_q == MID_SAMPLE;
    last    = tick && os_q == OS_LAST;
    load    = state_q == RX_STOP && mid;
    state_d = state_q;
    os_d    = tick ? os_q + 4'd1 : os_q;
    bi_d    = bi_q;
    sr_d    = sr_q;
    case (state_q)
      RX_IDLE: begin
        os_d = '0;
        if (!rxs) state_d = RX_START;
      end
      RX_START: begin
        if (mid && rxs) state_d = RX_IDLE;
        else if (last) begin
          state_d = RX_DATA;
          bi_d    = '0;
        end
      end
      RX_DATA: begin
        if (mid) sr_d = {rxs, sr_q[7:1]};
        if (last) begin
          state_d = bi_q == 3'd7 ? RX_STOP : RX_DATA;
          bi_d    = bi_q + 3'd1;
        end
      end
      RX_STOP:  if (load) state_d = rxs ? RX_IDLE : RX_BREAK;
      // a line held low after a bad stop bit must not look like a new start
      RX_BREAK: if (rxs) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      os_q    <= '0;
      bi_q    <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      os_q    <= os_d;
      bi_q    <= bi_d;
      sr_q    <= sr_d;
      if (load) begin
        data_q <= sr_q;
        ferr_q <= ~rxs;
        flag_q <= 1'b1;
        ovr_q  <= ovr_q | (flag_q & ~clr_flag);
      end else if (clr_flag) begin
        flag_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed frames into serial_rx with a scoreboard of expected characters
module tb_serial_rx;
  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, clr_flag = 1'b0;
  logic [7:0] rx_data;
  logic       rx_flag, framing_err, overrun, busy;
  int         n_cmp = 0, n_err = 0;
  typedef struct {logic [7:0] d; logic fe;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_rx #(.TICK_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .clr_flag    (clr_flag),
    .rx_data     (rx_data),
    .rx_flag     (rx_flag),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    sb.push_back('{d, ~stop});
    rx = 1'b0;
    clks(32);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      clks(32);
    end
    rx = stop;
    clks(32);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_flag"}, {7'b0, rx_flag}, 8'h01);
      chk({tag, "_data"}, rx_data, e.d);
      chk({tag, "_ferr"}, {7'b0, framing_err}, {7'b0, e.fe});
    end
  endtask

  task automatic pulse_clr();
    clr_flag = 1'b1;
    clks(1);
    clr_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) clks(1);
    chk(tag, {7'b0, busy}, 8'h00);
  endtask

  initial begin
    clks(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_flag", {7'b0, rx_flag}, 8'h00);
    chk("rst_ferr", {7'b0, framing_err}, 8'h00);
    chk("rst_ovr", {7'b0, overrun}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    reset = 1'b0;
    clks(2);
    send(8'h55, 1'b1);
    pop_chk("c55");
    chk("c55_busy", {7'b0, busy}, 8'h00);
    pulse_clr();
    chk("clr_flag", {7'b0, rx_flag}, 8'h00);
    chk("clr_data", rx_data, 8'h55);
    rx = 1'b0;
    clks(5);
    chk("glitch_busy", {7'b0, busy}, 8'h01);
    clks(5);
    rx = 1'b1;
    clks(14);
    chk("glitch_idle", {7'b0, busy}, 8'h00);
    chk("glitch_flag", {7'b0, rx_flag}, 8'h00);
    chk("glitch_data", rx_data, 8'h55);
    send(8'hA3, 1'b0);
    clks(64);
    pop_chk("cA3");
    chk("break_busy", {7'b0, busy}, 8'h01);
    rx = 1'b1;
    wait_idle("break_exit");
    pulse_clr();
    chk("clr_keep_ferr", {7'b0, framing_err}, 8'h01);
    chk("clr_flag2", {7'b0, rx_flag}, 8'h00);
    send(8'h0D, 1'b1);
    pop_chk("c0D");
    pulse_clr();
    send(8'h41, 1'b1);
    pop_chk("c41");
    chk("c41_ovr", {7'b0, overrun}, 8'h00);
    send(8'h42, 1'b1);
    pop_chk("c42");
    chk("c42_ovr", {7'b0, overrun}, 8'h01);
    pulse_clr();
    chk("ovr_clr_flag", {7'b0, rx_flag}, 8'h00);
    chk("ovr_clr", {7'b0, overrun}, 8'h00);
    send(8'h31, 1'b1);
    pop_chk("c31");
    fork
      send(8'h32, 1'b1);
      begin
        clks(306);
        clr_flag = 1'b1;
        clks(1);
        clr_flag = 1'b0;
      end
    join
    pop_chk("c32");
    chk("c32_ovr", {7'b0, overrun}, 8'h00);
    rx = 1'b0;
    clks(32 * 4);
    reset = 1'b1;
    clks(1);
    reset = 1'b0;
    rx = 1'b1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_flag", {7'b0, rx_flag}, 8'h00);
    chk("mid_rst_ferr", {7'b0, framing_err}, 8'h00);
    chk("mid_rst_ovr", {7'b0, overrun}, 8'h00);
    chk("mid_rst_busy", {7'b0, busy}, 8'h00);
    clks(64);
    chk("mid_rst_quiet", {7'b0, rx_flag}, 8'h00);
    send(8'h12, 1'b1);
    pop_chk("c12");
    chk("c12_ovr", {7'b0, overrun}, 8'h00);
    chk("sb_drained", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
